// File: rtl/muldiv_seq_pkg.sv
// rtl/muldiv_seq_pkg.sv - shared op encodings, FSM states and helpers for muldiv_seq
//
// Purpose: RV32M funct3 encodings, FSM state type and small decode helpers
//          shared by the muldiv_seq block.
// Ports:   none (package)

package muldiv_seq_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    function automatic logic is_div(input logic [2:0] f);
        return f[2];
    endfunction

    // rs1 is treated as signed for every signed op; MUL's low half is
    // sign-agnostic so treating it as signed is harmless.
    function automatic logic a_is_signed(input logic [2:0] f);
        return (f == OP_MUL) || (f == OP_MULH) || (f == OP_MULHSU) ||
               (f == OP_DIV) || (f == OP_REM);
    endfunction

    // rs2 is unsigned for MULHSU as well as the explicitly unsigned ops.
    function automatic logic b_is_signed(input logic [2:0] f);
        return (f == OP_MUL) || (f == OP_MULH) || (f == OP_DIV) || (f == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_negate.sv
// rtl/muldiv_negate.sv - conditional two's-complement negator
//
// Purpose: passes i_val through, or its two's-complement negation when i_en=1.
// Ports:   i_en  - negate enable
//          i_val - input value (W bits)
//          o_val - output value (W bits)

module muldiv_negate #(
    parameter int W = 32
) (
    input  logic         i_en,
    input  logic [W-1:0] i_val,
    output logic [W-1:0] o_val
);

    assign o_val = i_en ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - sequential radix-2 RV32M multiply/divide unit
//
// Purpose: executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU with one radix-2
//          step per cycle on operand magnitudes, then sign-corrects in FIX.
//          Fixed latency: done is high WIDTH+1 edges after the accept edge.
// Ports:   clk    - clock, rising edge
//          reset  - synchronous active-high reset
//          start  - request, sampled only while busy=0
//          op     - RV32M funct3
//          a, b   - operands (rs1/dividend, rs2/divisor), captured at accept
//          busy   - operation in progress, inputs ignored
//          done   - one-cycle result-valid pulse
//          result - registered result, held until the next done

module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_op;
    logic               r_sign_a;
    logic               r_sign_b;
    logic               r_divz;
    logic [WIDTH-1:0]   r_a_raw;
    // Multiply: r_opa = shifting multiplicand, r_opb = shifting multiplier,
    //           r_acc = 2W partial product.
    // Divide:   r_opb = divisor, r_acc = {remainder, dividend/quotient}.
    logic [2*WIDTH-1:0] r_opa;
    logic [WIDTH-1:0]   r_opb;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;

    logic               w_sign_a;
    logic               w_sign_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_last;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH:0]     w_diff;
    logic               w_borrow;
    logic [2*WIDTH-1:0] w_res_in;
    logic               w_res_neg_en;
    logic [2*WIDTH-1:0] w_res_out;
    logic [WIDTH-1:0]   w_final;

    assign w_sign_a = a[WIDTH-1] & a_is_signed(op);
    assign w_sign_b = b[WIDTH-1] & b_is_signed(op);

    muldiv_negate #(.W(WIDTH)) u_neg_a (
        .i_en  (w_sign_a),
        .i_val (a),
        .o_val (w_mag_a)
    );

    muldiv_negate #(.W(WIDTH)) u_neg_b (
        .i_en  (w_sign_b),
        .i_val (b),
        .o_val (w_mag_b)
    );

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    // Restoring step: the top bit of w_diff is the borrow because the
    // shifted remainder is always below twice the divisor.
    assign w_trial  = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff   = w_trial - {1'b0, r_opb};
    assign w_borrow = w_diff[WIDTH];

    // Quotient and remainder are zero-extended into the 2W negator; the low
    // W bits of the negation equal a W-bit negation.
    always_comb begin
        w_res_in     = r_acc;
        w_res_neg_en = r_sign_a ^ r_sign_b;
        case (r_op)
            OP_DIV, OP_DIVU: begin
                w_res_in     = {{WIDTH{1'b0}}, r_acc[WIDTH-1:0]};
                w_res_neg_en = r_sign_a ^ r_sign_b;
            end
            OP_REM, OP_REMU: begin
                w_res_in     = {{WIDTH{1'b0}}, r_acc[2*WIDTH-1:WIDTH]};
                w_res_neg_en = r_sign_a;
            end
            default: begin
                w_res_in     = r_acc;
                w_res_neg_en = r_sign_a ^ r_sign_b;
            end
        endcase
    end

    muldiv_negate #(.W(2*WIDTH)) u_neg_res (
        .i_en  (w_res_neg_en),
        .i_val (w_res_in),
        .o_val (w_res_out)
    );

    // Divide-by-zero results are forced here and win over sign correction.
    // Signed overflow needs no special case: |a|/1 with equal signs already
    // yields -2^(WIDTH-1) and a zero remainder.
    always_comb begin
        w_final = w_res_out[WIDTH-1:0];
        case (r_op)
            OP_MUL:                       w_final = w_res_out[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_res_out[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              w_final = r_divz ? {WIDTH{1'b1}} : w_res_out[WIDTH-1:0];
            default:                      w_final = r_divz ? r_a_raw : w_res_out[WIDTH-1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_CALC;
            ST_CALC: if (w_last) w_next = ST_FIX;
            ST_FIX:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_divz   <= 1'b0;
            r_a_raw  <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_acc    <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= (r_state == ST_FIX);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op     <= op;
                        r_sign_a <= w_sign_a;
                        r_sign_b <= w_sign_b;
                        r_divz   <= (b == '0);
                        r_a_raw  <= a;
                        r_cnt    <= '0;
                        r_opb    <= w_mag_b;
                        if (is_div(op)) begin
                            r_acc <= {{WIDTH{1'b0}}, w_mag_a};
                            r_opa <= '0;
                        end else begin
                            r_acc <= '0;
                            r_opa <= {{WIDTH{1'b0}}, w_mag_a};
                        end
                    end
                end
                ST_CALC: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (is_div(r_op)) begin
                        if (w_borrow) begin
                            r_acc <= {r_acc[2*WIDTH-2:0], 1'b0};
                        end else begin
                            r_acc <= {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
                        end
                    end else begin
                        if (r_opb[0]) begin
                            r_acc <= r_acc + r_opa;
                        end
                        r_opa <= r_opa << 1;
                        r_opb <= r_opb >> 1;
                    end
                end
                ST_FIX: begin
                    r_result <= w_final;
                    r_cnt    <= '0;
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state != ST_IDLE);
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - directed and reference-model bench for muldiv_seq

module tb_muldiv_seq;

    localparam int W  = 32;
    localparam int W8 = 8;

    localparam logic [2:0] T_MUL    = 3'b000;
    localparam logic [2:0] T_MULH   = 3'b001;
    localparam logic [2:0] T_MULHSU = 3'b010;
    localparam logic [2:0] T_MULHU  = 3'b011;
    localparam logic [2:0] T_DIV    = 3'b100;
    localparam logic [2:0] T_DIVU   = 3'b101;
    localparam logic [2:0] T_REM    = 3'b110;
    localparam logic [2:0] T_REMU   = 3'b111;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    logic         s8_start;
    logic [2:0]   s8_op;
    logic [7:0]   s8_a;
    logic [7:0]   s8_b;
    logic         s8_busy;
    logic         s8_done;
    logic [7:0]   s8_result;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    muldiv_seq #(.WIDTH(W)) u_dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    muldiv_seq #(.WIDTH(W8)) u_dut8 (
        .clk    (clk),
        .reset  (reset),
        .start  (s8_start),
        .op     (s8_op),
        .a      (s8_a),
        .b      (s8_b),
        .busy   (s8_busy),
        .done   (s8_done),
        .result (s8_result)
    );

    // Latency counts the accept cycle as cycle 1; done is expected in cycle W+2.
    task automatic run_op(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [W-1:0] res, output int lat, output bit timeout);
        start = 1'b1; op = f; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        lat = 1;
        timeout = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done) begin
                timeout = 1'b0;
                break;
            end
        end
        res = result;
    endtask

    function automatic logic [7:0] ref8(input logic [2:0] f, input logic [7:0] x, input logic [7:0] y);
        int sx, sy, ux, uy, p;
        sx = int'($signed(x)); sy = int'($signed(y));
        ux = int'(x);          uy = int'(y);
        case (f)
            T_MUL:    begin p = sx * sy; return 8'(p); end
            T_MULH:   begin p = sx * sy; return 8'(p >>> 8); end
            T_MULHSU: begin p = sx * uy; return 8'(p >>> 8); end
            T_MULHU:  begin p = ux * uy; return 8'(p >>> 8); end
            T_DIV: begin
                if (y == 8'h00) return 8'hFF;
                if (x == 8'h80 && y == 8'hFF) return 8'h80;
                return 8'(sx / sy);
            end
            T_DIVU: begin
                if (y == 8'h00) return 8'hFF;
                return 8'(ux / uy);
            end
            T_REM: begin
                if (y == 8'h00) return x;
                if (x == 8'h80 && y == 8'hFF) return 8'h00;
                return 8'(sx % sy);
            end
            default: begin
                if (y == 8'h00) return x;
                return 8'(ux % uy);
            end
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        s8_start = 1'b0; s8_op = '0; s8_a = '0; s8_b = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b want=0", busy); end
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b want=0", done); end
        vectors++;
        if (result !== '0) begin miscompares++; $display("FAIL reset_result got=%h want=0", result); end
        reset = 1'b0;
    endtask

    task automatic test_mul();
        logic [2:0]   f   [4] = '{T_MULHU, T_MUL, T_MULH, T_MULHSU};
        logic [W-1:0] xa  [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF};
        logic [W-1:0] xb  [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFF};
        logic [W-1:0] exp [4] = '{32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [W-1:0] res;
        int           lat;
        bit           to;
        for (int i = 0; i < 4; i++) begin
            run_op(f[i], xa[i], xb[i], res, lat, to);
            vectors++;
            if (to || res !== exp[i]) begin
                miscompares++;
                $display("FAIL mul[%0d] op=%0d got=%h want=%h timeout=%0d", i, f[i], res, exp[i], to);
            end
            vectors++;
            if (lat != W + 2) begin miscompares++; $display("FAIL mul_latency[%0d] got=%0d want=%0d", i, lat, W + 2); end
        end
    endtask

    task automatic test_div();
        logic [2:0]   f   [4] = '{T_DIV, T_REM, T_DIVU, T_REMU};
        logic [W-1:0] xa  [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
        logic [W-1:0] xb  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [W-1:0] exp [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
        logic [W-1:0] res;
        int           lat;
        bit           to;
        for (int i = 0; i < 4; i++) begin
            run_op(f[i], xa[i], xb[i], res, lat, to);
            vectors++;
            if (to || res !== exp[i]) begin
                miscompares++;
                $display("FAIL div[%0d] op=%0d got=%h want=%h timeout=%0d", i, f[i], res, exp[i], to);
            end
            vectors++;
            if (lat != W + 2) begin miscompares++; $display("FAIL div_latency[%0d] got=%0d want=%0d", i, lat, W + 2); end
        end
    endtask

    task automatic test_div_corner();
        logic [2:0]   f   [6] = '{T_DIV, T_DIVU, T_REM, T_REMU, T_DIV, T_REM};
        logic [W-1:0] xa  [6] = '{32'h80000001, 32'h80000001, 32'h80000001, 32'h80000001,
                                  32'h80000000, 32'h80000000};
        logic [W-1:0] xb  [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [W-1:0] exp [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 32'h80000001,
                                  32'h80000000, 32'h00000000};
        logic [W-1:0] res;
        int           lat;
        bit           to;
        for (int i = 0; i < 6; i++) begin
            run_op(f[i], xa[i], xb[i], res, lat, to);
            vectors++;
            if (to || res !== exp[i]) begin
                miscompares++;
                $display("FAIL corner[%0d] op=%0d got=%h want=%h timeout=%0d", i, f[i], res, exp[i], to);
            end
        end
    endtask

    task automatic test_start_held();
        int dones = 0;
        int first = -1;
        int second = -1;
        start = 1'b1; op = T_DIVU; a = 32'd100; b = 32'd7;
        for (int i = 0; i < 102; i++) begin
            @(posedge clk); #1;
            if (done) begin
                dones++;
                if (first < 0) first = i; else if (second < 0) second = i;
                vectors++;
                if (result !== 32'd14 || busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL held_result got=%h busy=%b want=0000000e busy=0", result, busy);
                end
            end
            if (i == 101) start = 1'b0;
        end
        vectors++;
        if (dones != 3) begin miscompares++; $display("FAIL held_done_count got=%0d want=3", dones); end
        vectors++;
        if (second - first != W + 2) begin
            miscompares++;
            $display("FAIL held_interval got=%0d want=%0d", second - first, W + 2);
        end
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL held_idle_after got=%b want=0", busy); end
    endtask

    task automatic test_busy_ignore();
        int  dones = 0;
        bit  seen = 1'b0;
        start = 1'b1; op = T_MUL; a = 32'd3; b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        start = 1'b1; op = T_DIVU; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (done) begin seen = 1'b1; break; end
        end
        vectors++;
        if (!seen || result !== 32'd15) begin
            miscompares++;
            $display("FAIL busy_ignore_result got=%h want=0000000f seen=%0d", result, seen);
        end
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        vectors++;
        if (dones != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_ignore_queued dones=%0d busy=%b want dones=0 busy=0", dones, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] res;
        int           lat;
        bit           to;
        run_op(T_MULHU, 32'hFFFFFFFF, 32'd2, res, lat, to);
        vectors++;
        if (to || res !== 32'h00000001) begin
            miscompares++;
            $display("FAIL b2b_first got=%h want=00000001 timeout=%0d", res, to);
        end
        start = 1'b1; op = T_MUL; a = 32'd6; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_accept busy=%b done=%b want busy=1 done=0", busy, done);
        end
        lat = 1; to = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done) begin to = 1'b0; break; end
        end
        vectors++;
        if (to || result !== 32'd42 || lat != W + 2) begin
            miscompares++;
            $display("FAIL b2b_second got=%h lat=%0d want=0000002a lat=%0d", result, lat, W + 2);
        end
    endtask

    task automatic test_reset_mid();
        int           dones = 0;
        logic [W-1:0] res;
        int           lat;
        bit           to;
        start = 1'b1; op = T_DIV; a = 32'hFFFFFFF9; b = 32'd2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL midreset_pre_busy got=%b want=1", busy); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
            miscompares++;
            $display("FAIL midreset_state busy=%b done=%b result=%h want 0 0 0", busy, done, result);
        end
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        vectors++;
        if (dones != 0) begin miscompares++; $display("FAIL midreset_spurious_done got=%0d want=0", dones); end
        run_op(T_REM, 32'hFFFFFFF9, 32'd2, res, lat, to);
        vectors++;
        if (to || res !== 32'hFFFFFFFF || lat != W + 2) begin
            miscompares++;
            $display("FAIL midreset_recover got=%h lat=%0d want=ffffffff lat=%0d", res, lat, W + 2);
        end
    endtask

    task automatic test_w8_random();
        logic [2:0] f;
        logic [7:0] x, y, exp;
        int         lat;
        bit         to;
        for (int n = 0; n < 48; n++) begin
            f = 3'(n % 8);
            x = 8'($urandom);
            y = 8'($urandom);
            if (n >= 32 && n < 40) y = 8'h00;
            if (n >= 40) begin x = 8'h80; y = 8'hFF; end
            exp = ref8(f, x, y);
            s8_start = 1'b1; s8_op = f; s8_a = x; s8_b = y;
            @(posedge clk); #1;
            s8_start = 1'b0; s8_a = 8'($urandom); s8_b = 8'($urandom);
            lat = 1; to = 1'b1;
            for (int i = 0; i < 100; i++) begin
                @(posedge clk); #1;
                lat++;
                if (s8_done) begin to = 1'b0; break; end
            end
            vectors++;
            if (to || s8_result !== exp || lat != W8 + 2) begin
                miscompares++;
                $display("FAIL w8[%0d] op=%0d a=%h b=%h got=%h lat=%0d want=%h lat=%0d",
                         n, f, x, y, s8_result, lat, exp, W8 + 2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_corner();
        test_start_held();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_w8_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
